// File: rtl/axis_packet_fifo_if.sv
// AXI-Stream channel carrying {tlast,tstrb,tdata} with valid/ready handshake.
// Master drives the payload and valid; slave drives ready.
interface axis_packet_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_packet_fifo.sv
// Single-clock AXI-Stream FIFO with optional store-and-forward on tlast.
// Oversize packets force cut-through until their tlast drains.
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int PACKET_MODE = 0,
    parameter int ALMOST_FULL = 4032
) (
    input  logic                 axis_aclk,
    input  logic                 axis_aresetn,
    axis_packet_fifo_if.slave    s01_axis,
    axis_packet_fifo_if.master   m01_axis,
    output logic [ADDR_WIDTH:0]  fill_count,
    output logic                 almost_full,
    output logic                 pkt_oversize
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WORD_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int MEM_SIZE   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH + 1)'(1);

    logic [WORD_WIDTH-1:0] mem [MEM_SIZE];
    logic [WORD_WIDTH-1:0] head;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   pkt_count;
    logic                  started;
    logic                  rel_q;
    logic                  empty;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;
    logic                  wr_last;
    logic                  rd_last;
    logic                  out_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign head = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // rel_q lets an oversize packet stream out so the FIFO cannot deadlock
    assign out_ok = (PACKET_MODE == 0) || (pkt_count != '0) || rel_q;

    assign s01_axis.tready = started && !full;
    assign m01_axis.tvalid = !empty && out_ok;
    assign m01_axis.tlast  = head[WORD_WIDTH-1];
    assign m01_axis.tstrb  = head[WORD_WIDTH-2 -: STRB_WIDTH];
    assign m01_axis.tdata  = head[DATA_WIDTH-1:0];

    assign wr_en   = s01_axis.tvalid && s01_axis.tready;
    assign rd_en   = m01_axis.tvalid && m01_axis.tready;
    assign wr_last = wr_en && s01_axis.tlast;
    assign rd_last = rd_en && head[WORD_WIDTH-1];

    assign almost_full = (fill_count >= AF_LVL);

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s01_axis.tlast,
                                            s01_axis.tstrb,
                                            s01_axis.tdata};
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            started      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_count   <= '0;
            pkt_count    <= '0;
            rel_q        <= 1'b0;
            pkt_oversize <= 1'b0;
        end else begin
            started <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + ONE;
            if (rd_en) rd_ptr <= rd_ptr + ONE;

            case ({wr_en, rd_en})
                2'b10:   fill_count <= fill_count + ONE;
                2'b01:   fill_count <= fill_count - ONE;
                default: fill_count <= fill_count;
            endcase

            case ({wr_last, rd_last})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase

            // full with no complete packet stored: release and flag
            if ((PACKET_MODE != 0) && full && (pkt_count == '0)) begin
                pkt_oversize <= 1'b1;
                rel_q        <= 1'b1;
            end else if (rd_last) begin
                rel_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: cut-through and store-and-forward instances
// checked against a scoreboard of accepted words.
module tb_axis_packet_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axis_packet_fifo_if #(.DATA_WIDTH(32)) s0 ();
    axis_packet_fifo_if #(.DATA_WIDTH(32)) m0 ();
    axis_packet_fifo_if #(.DATA_WIDTH(32)) s1 ();
    axis_packet_fifo_if #(.DATA_WIDTH(32)) m1 ();

    logic [12:0] fc0;
    logic [12:0] fc1;
    logic        af0;
    logic        af1;
    logic        ov0;
    logic        ov1;

    axis_packet_fifo #(.PACKET_MODE(0)) d0 (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s01_axis     (s0),
        .m01_axis     (m0),
        .fill_count   (fc0),
        .almost_full  (af0),
        .pkt_oversize (ov0)
    );

    axis_packet_fifo #(.PACKET_MODE(1)) d1 (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .s01_axis     (s1),
        .m01_axis     (m1),
        .fill_count   (fc1),
        .almost_full  (af1),
        .pkt_oversize (ov1)
    );

    logic        sel = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;

    assign s0.tdata  = s_tdata;
    assign s0.tstrb  = s_tstrb;
    assign s0.tlast  = s_tlast;
    assign s0.tvalid = s_tvalid && !sel;
    assign m0.tready = m_tready && !sel;
    assign s1.tdata  = s_tdata;
    assign s1.tstrb  = s_tstrb;
    assign s1.tlast  = s_tlast;
    assign s1.tvalid = s_tvalid && sel;
    assign m1.tready = m_tready && sel;

    logic        o_sready;
    logic        o_tvalid;
    logic        o_tlast;
    logic [3:0]  o_tstrb;
    logic [31:0] o_tdata;
    logic [12:0] o_fill;

    assign o_sready = sel ? s1.tready : s0.tready;
    assign o_tvalid = sel ? m1.tvalid : m0.tvalid;
    assign o_tlast  = sel ? m1.tlast  : m0.tlast;
    assign o_tstrb  = sel ? m1.tstrb  : m0.tstrb;
    assign o_tdata  = sel ? m1.tdata  : m0.tdata;
    assign o_fill   = sel ? fc1 : fc0;

    int n_chk = 0;
    int n_bad = 0;
    logic [36:0] sb[$];
    logic [36:0] exp_w;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // words are pushed on acceptance and popped on each output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_tvalid && o_sready) sb.push_back({s_tlast, s_tstrb, s_tdata});
            if (o_tvalid && m_tready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    chk("out_word", {o_tlast, o_tstrb, o_tdata}, exp_w);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [3:0] st,
                        input logic l);
        bit done = 1'b0;
        s_tdata  = d;
        s_tstrb  = st;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (o_sready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        chk("push_done", done, 1);
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int c = 0; c < 5000 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_done", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready0", s0.tready, 0);
        chk("rst_sready1", s1.tready, 0);
        chk("rst_tvalid0", m0.tvalid, 0);
        chk("rst_fill0", fc0, 0);
        chk("rst_af0", af0, 0);
        chk("rst_ov1", ov1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("sready_pre", s0.tready, 0);
        @(posedge clk);
        #1;
        chk("sready_post0", s0.tready, 1);
        chk("sready_post1", s1.tready, 1);

        // cut-through, three single-word packets
        sel = 1'b0;
        m_tready = 1'b0;
        push(32'h55, 4'hF, 1'b1);
        push(32'h22, 4'hF, 1'b1);
        push(32'h24, 4'hF, 1'b1);
        chk("ct_fill3", fc0, 3);
        chk("ct_tvalid", m0.tvalid, 1);
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ct_fill0", fc0, 0);
        chk("ct_sb_empty", sb.size(), 0);
        m_tready = 1'b0;

        // two complete fills; the second runs with wrapped pointers
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4096; i++) begin
                int n;
                push(32'(i) ^ (pass != 0 ? 32'hA5A5_0000 : 32'h0),
                     4'(i), (i % 7) == 6);
                n = i + 1;
                if (n == 4031 || n == 4032 || n == 4096) begin
                    chk("fill_lvl", fc0, 64'(n));
                    chk("almost_full", af0, 64'(n >= 4032));
                end
            end
            chk("full_sready", o_sready, 0);
            m_tready = 1'b1;
            chk("full_rd_sready", o_sready, 0);
            @(posedge clk);
            #1;
            chk("space_after", o_sready, 1);
            chk("fill_4095", fc0, 4095);
            drain();
            chk("fill_empty", fc0, 0);
            chk("af_empty", af0, 0);
            m_tready = 1'b0;
        end

        // simultaneous write and read at fill 5
        for (int i = 0; i < 5; i++) push(32'h100 + 32'(i), 4'h3, 1'b0);
        chk("sim_fill5", fc0, 5);
        s_tdata  = 32'h1FF;
        s_tstrb  = 4'hC;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        chk("sim_fill_hold", fc0, 5);
        drain();
        chk("sim_fill0", fc0, 0);
        m_tready = 1'b0;

        // store-and-forward holds output until tlast is stored
        sel = 1'b1;
        m_tready = 1'b1;
        push(32'hA1, 4'h1, 1'b0);
        push(32'hA2, 4'h2, 1'b0);
        chk("sf_hold", o_tvalid, 0);
        chk("sf_fill2", fc1, 2);
        push(32'hA3, 4'h4, 1'b1);
        chk("sf_release", o_tvalid, 1);
        drain();
        chk("sf_fill0", fc1, 0);

        // oversize packet streams out once the FIFO fills
        for (int i = 0; i < 4097; i++) begin
            push(32'h0B00_0000 + 32'(i), 4'hF, i == 4096);
            if (i == 4094) chk("ov_before", ov1, 0);
        end
        chk("ov_set", ov1, 1);
        drain();
        chk("ov_fill0", fc1, 0);
        push(32'hAA, 4'h5, 1'b0);
        push(32'hBB, 4'h6, 1'b0);
        chk("sf_reenter", o_tvalid, 0);
        push(32'hCC, 4'h7, 1'b1);
        chk("sf_reenter_rel", o_tvalid, 1);
        drain();
        chk("ov_sticky", ov1, 1);

        // reset mid-packet discards everything
        m_tready = 1'b0;
        push(32'hD1, 4'h1, 1'b0);
        push(32'hD2, 4'h1, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_ov", ov1, 0);
        chk("mid_rst_fill", fc1, 0);
        chk("mid_rst_tvalid", m1.tvalid, 0);
        chk("mid_rst_sready", s1.tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_up", s1.tready, 1);
        chk("mid_rst_empty", m1.tvalid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
